// File: rtl/sum_stream_accumulator.sv
// Groups a stream of unsigned sums into totals of up to n items; a group closes
// after n accepted items or on an item flagged in_last. Result is held until drained.
module sum_stream_accumulator #(
  parameter int unsigned width = 5,
  parameter int unsigned n     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_vld,
  output logic                        in_rdy,
  input  logic [width-1:0]            in_data,
  input  logic                        in_last,
  output logic                        out_vld,
  input  logic                        out_rdy,
  output logic [width+$clog2(n)-1:0]  out_data,
  output logic [$clog2(n):0]          out_cnt
);

  localparam int unsigned cw = $clog2(n) + 1;
  localparam int unsigned ow = width + $clog2(n);

  logic [ow-1:0] acc_q, acc_d;
  logic [cw-1:0] cnt_q, cnt_d;
  logic          out_vld_q, out_vld_d;
  logic [ow-1:0] out_data_q, out_data_d;
  logic [cw-1:0] out_cnt_q, out_cnt_d;

  logic          close_would_occur;
  logic          accept;
  logic          closing;
  logic [ow-1:0] sum;
  logic [cw-1:0] cnt_inc;

  // Only the item that would overwrite a stalled result is blocked; this is a
  // deliberate combinational path from out_rdy/in_last to in_rdy.
  assign close_would_occur = (cnt_q == cw'(n - 1)) || in_last;
  assign in_rdy            = !(out_vld_q && !out_rdy && close_would_occur);
  assign accept            = in_vld && in_rdy;
  assign closing           = accept && close_would_occur;
  assign sum               = acc_q + ow'(in_data);
  assign cnt_inc           = cnt_q + cw'(1);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (accept) begin
      if (closing) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_inc;
      end
    end
  end

  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_cnt_d  = out_cnt_q;
    if (out_vld_q && out_rdy) out_vld_d = 1'b0;
    // A close in the drain cycle reloads immediately, so back-to-back groups see no bubble.
    if (closing) begin
      out_vld_d  = 1'b1;
      out_data_d = sum;
      out_cnt_d  = cnt_inc;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_cnt_q  <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_cnt_q  <= out_cnt_d;
    end
  end

  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign out_cnt  = out_cnt_q;

endmodule
